vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be H_DISPLAY=640, H_FRONT=16, H_SYNC=96, H_BACK=48, V_DISPLAY=480, V_BOTTOM=10, V_SYNC=2, V_TOP=33, LOCK_FRAMES=2 (good frames needed to lock).
REQ-002 Derived constants SHALL be H_TOTAL=800, V_TOTAL=525, H_SYNC_START=656, V_SYNC_START=490.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 hsync_in  in  1  active-high horizontal sync, synchronous to clk.
REQ-006 vsync_in  in  1  active-high vertical sync, synchronous to clk.
REQ-007 hpos_rec  out  10  recovered pixel column.
REQ-008 vpos_rec  out  10  recovered line.
REQ-009 display_on_rec  out  1  locked and hpos_rec<H_DISPLAY and vpos_rec<V_DISPLAY, combinational from registers.
REQ-010 locked  out  1  high only in state LOCKED.
REQ-011 frame_start  out  1  one-cycle pulse on each vsync rise while locked.
REQ-012 sync_err  out  1  one-cycle pulse on loss of lock.

Function
REQ-013 A rise SHALL be input==1 while its registered previous sample==0, evaluated in the same cycle.
REQ-014 hpos_rec SHALL increment each cycle, wrap from H_TOTAL-1 to 0, and load H_SYNC_START on the edge following an hsync rise.
REQ-015 vpos_rec SHALL increment on each hpos_rec wrap, wrap from V_TOTAL-1 to 0, and load V_SYNC_START on the edge following a vsync rise; the vsync load overrides the wrap increment.
REQ-016 An 11-bit h_period counter SHALL count cycles between hsync rises, resetting to 1 on each rise, saturating at 2047.
REQ-017 An 11-bit line counter SHALL count hsync rises since the last vsync rise; a simultaneous hsync and vsync rise counts toward the ending frame.
REQ-018 A line SHALL be bad if its period at the hsync rise is not H_TOTAL; the first rise after entering MEASURE is not checked.
REQ-019 A frame SHALL be good if line count==V_TOTAL at the vsync rise and no bad line occurred in it.
REQ-020 States SHALL be SEARCH, MEASURE, LOCKED.
REQ-021 SEARCH -> MEASURE on a vsync rise, clearing good_frames, line counter and bad-line flag.
REQ-022 MEASURE: at each vsync rise, a good frame increments good_frames; reaching LOCK_FRAMES -> LOCKED; a bad frame clears good_frames and stays in MEASURE.
REQ-023 LOCKED -> SEARCH with sync_err pulse on any bad line, bad frame, or h_period reaching 2*H_TOTAL.
REQ-024 MEASURE -> SEARCH, without sync_err, when h_period reaches 2*H_TOTAL.
REQ-025 frame_start SHALL assert in the cycle after a vsync rise that occurs while LOCKED.

Reset
REQ-026 Reset SHALL set state SEARCH, hpos_rec=0, vpos_rec=0, all counters 0, edge registers 0, and locked, frame_start, sync_err low.
REQ-027 Reset mid-frame SHALL discard all measurement; lock requires a fresh vsync rise plus LOCK_FRAMES good frames.

Configuration
REQ-028 With VGA_DEC_STATS_EN defined, outputs last_h_period[10:0], last_v_lines[10:0] and err_count[7:0] SHALL exist: latched at each hsync and vsync rise respectively; err_count increments per sync_err, saturating at 255, and resets to 0.
REQ-029 Without VGA_DEC_STATS_EN, those ports and registers SHALL be absent and all other behaviour is identical.

Verification
REQ-030 Nominal 800x525 sync stream from reset -> locked rises after the third vsync rise (1 arming + 2 good frames); frame_start pulses on every later vsync rise.
REQ-031 Once locked, one 799-cycle line -> sync_err pulse at that hsync rise, locked low the next cycle, relock after 3 further vsync rises.
REQ-032 Once locked, a frame of 524 lines -> sync_err and state SEARCH at the vsync rise.
REQ-033 hsync_in held low 1600 cycles while locked -> sync_err, locked low; the same while in MEASURE -> SEARCH, no sync_err.
REQ-034 Reset asserted mid-frame while locked -> all outputs zero the next cycle; lock regained only after 3 vsync rises.
REQ-035 With VGA_DEC_STATS_EN, nominal stream -> last_h_period=800, last_v_lines=525; after REQ-031 fault -> err_count=1.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers raster position from hsync/vsync and qualifies lock over whole frames.
// Optional VGA_DEC_STATS_EN adds last_h_period, last_v_lines and err_count.
module vga_sync_decoder #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_BOTTOM    = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOP       = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos_rec,
  output logic [9:0] vpos_rec,
  output logic       display_on_rec,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
`ifdef VGA_DEC_STATS_EN
  ,
  output logic [10:0] last_h_period,
  output logic [10:0] last_v_lines,
  output logic [7:0]  err_count
`endif
);
  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t      state;
  logic        hs_d, vs_d, bad, first_rise;
  logic [10:0] h_period, lines, lines_tot;
  logic [7:0]  good_frames;
  logic        h_rise, v_rise, h_wrap, line_bad, timeout, frame_ok, err_now;
  always_comb begin
    h_rise    = hsync_in & ~hs_d;
    v_rise    = vsync_in & ~vs_d;
    h_wrap    = ~h_rise && hpos_rec == 10'(H_TOTAL - 1);
    // the first rise after arming has no trustworthy reference period
    line_bad  = h_rise && h_period != 11'(H_TOTAL) && state != SEARCH && !(state == MEASURE && first_rise);
    timeout   = h_period >= 11'(2 * H_TOTAL);
    lines_tot = lines + 11'(h_rise);
    frame_ok  = lines_tot == 11'(V_TOTAL) && !bad && !line_bad;
    err_now   = state == LOCKED && (line_bad || timeout || (v_rise && !frame_ok));
  end
  assign locked         = state == LOCKED;
  assign display_on_rec = locked && hpos_rec < 10'(H_DISPLAY) && vpos_rec < 10'(V_DISPLAY);
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      hpos_rec    <= '0;
      vpos_rec    <= '0;
      h_period    <= '0;
      lines       <= '0;
      good_frames <= '0;
      bad         <= 1'b0;
      first_rise  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      hs_d        <= hsync_in;
      vs_d        <= vsync_in;
      hpos_rec    <= h_rise ? 10'(H_SYNC_START) : hpos_rec == 10'(H_TOTAL - 1) ? '0 : hpos_rec + 10'd1;
      vpos_rec    <= v_rise ? 10'(V_SYNC_START) : !h_wrap ? vpos_rec : vpos_rec == 10'(V_TOTAL - 1) ? '0 : vpos_rec + 10'd1;
      h_period    <= h_rise ? 11'd1 : h_period == '1 ? h_period : h_period + 11'd1;
      lines       <= v_rise ? '0 : (h_rise && lines != '1) ? lines + 11'd1 : lines;
      bad         <= v_rise ? 1'b0 : bad | line_bad;
      frame_start <= locked && v_rise;
      sync_err    <= err_now;
      if (h_rise && state == MEASURE) first_rise <= 1'b0;
      case (state)
        SEARCH:
          if (v_rise) begin
            state       <= MEASURE;
            good_frames <= '0;
            first_rise  <= 1'b1;
          end
        MEASURE:
          if (timeout) state <= SEARCH;
          else if (v_rise) begin
            good_frames <= frame_ok ? good_frames + 8'd1 : '0;
            if (frame_ok && good_frames + 8'd1 == 8'(LOCK_FRAMES)) state <= LOCKED;
          end
        LOCKED:
          if (err_now) state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end
`ifdef VGA_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_h_period <= '0;
      last_v_lines  <= '0;
      err_count     <= '0;
    end else begin
      if (h_rise) last_h_period <= h_period;
      if (v_rise) last_v_lines <= lines_tot;
      if (err_now && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized sync streams with faults, checked every cycle against a timestamp-based model.
module tb_vga_sync_decoder;
  localparam int HD = 16, HF = 4, HSW = 8, HB = 4, VD = 12, VB = 2, VSW = 2, VTP = 4;
  localparam int HT = HD + HF + HSW + HB, VT = VD + VB + VSW + VTP;
  localparam int HSS = HD + HF, VSS = VD + VB;
  logic clk = 0, reset = 1, hsync_in = 0, vsync_in = 0;
  logic [9:0] hpos_rec, vpos_rec;
  logic display_on_rec, locked, frame_start, sync_err;
`ifdef VGA_DEC_STATS_EN
  logic [10:0] last_h_period, last_v_lines;
  logic [7:0] err_count;
`endif
  vga_sync_decoder #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VTP), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hpos_rec(hpos_rec), .vpos_rec(vpos_rec), .display_on_rec(display_on_rec),
    .locked(locked), .frame_start(frame_start), .sync_err(sync_err)
`ifdef VGA_DEC_STATS_EN
    , .last_h_period(last_h_period), .last_v_lines(last_v_lines), .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  int n_total = 0, n_bad = 0;
  int gh = 0, gv = 0, hlen = HT, vlen = VT, hadj = 0, vadj = 0, hmask = 0, rst_req = 0;
  bit rnd = 0, valid = 0;
  int t = 0, m_state = 0, m_phs = 0, m_pvs = 0, ha_t = 0, ha_v = 0, hbase = 0, m_v = 0;
  int m_lines = 0, m_gf = 0, m_bad = 0, m_first = 0, e_fs = 0, e_se = 0, m_hr = 0, m_rst = 1;
  int n_vr = 0, n_serr = 0, n_fs = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
    end
  endtask
  task automatic step();
    int e_h, cur_h, per, ltot, r;
    bit hs, vs, hr, vr, badnow, fok, tout;
    @(negedge clk);
    if (valid) begin
      e_h = (ha_v + t - ha_t) % HT;
      chk("hpos", int'(hpos_rec), e_h);
      chk("vpos", int'(vpos_rec), m_v);
      chk("locked", int'(locked), int'(m_state == 2));
      chk("frame_start", int'(frame_start), e_fs);
      chk("sync_err", int'(sync_err), e_se);
      chk("display_on", int'(display_on_rec), int'(m_state == 2 && e_h < HD && m_v < VD));
      if (m_hr && !m_rst) chk("hpos_after_hrise", int'(hpos_rec), HSS);
      n_serr += int'(sync_err);
      n_fs += int'(frame_start);
    end
    hs = gh >= HSS && gh < HSS + HSW && hmask == 0;
    vs = gv >= VSS && gv < VSS + VSW;
    if (hmask > 0) hmask--;
    gh++;
    if (gh >= hlen) begin
      gh = 0; hlen = HT + hadj; hadj = 0; gv++;
      if (rnd) begin
        r = $urandom_range(0, 59);
        if (r == 0) hlen = HT - 1;
        else if (r == 1) hlen = HT + 1;
        else if (r == 2) hmask = 2 * HT + 3;
      end
      if (gv >= vlen) begin
        gv = 0; vlen = VT + vadj; vadj = 0;
        if (rnd && $urandom_range(0, 7) == 0) vlen = VT - 1 + 2 * int'($urandom_range(0, 1));
        if (rnd && $urandom_range(0, 19) == 0) rst_req = 2;
      end
    end
    hsync_in = hs; vsync_in = vs;
    reset = rst_req > 0;
    if (rst_req > 0) rst_req--;
    t++;
    m_rst = int'(reset);
    e_fs = 0; e_se = 0; m_hr = 0;
    if (reset) begin
      m_state = 0; m_phs = 0; m_pvs = 0; ha_t = t; ha_v = 0; hbase = t; m_v = 0;
      m_lines = 0; m_gf = 0; m_bad = 0; m_first = 0; n_vr = 0;
    end else begin
      cur_h = (ha_v + t - 1 - ha_t) % HT;
      per = t - 1 - hbase; if (per > 2047) per = 2047;
      hr = hs && !m_phs; vr = vs && !m_pvs;
      m_hr = int'(hr);
      badnow = hr && per != HT && m_state != 0 && !(m_state == 1 && m_first);
      ltot = m_lines + int'(hr);
      fok = ltot == VT && !m_bad && !badnow;
      tout = per >= 2 * HT;
      e_fs = int'(m_state == 2 && vr);
      if (vr) begin m_v = VSS; n_vr++; end
      else if (cur_h == HT - 1 && !hr) m_v = (m_v + 1) % VT;
      if (hr) begin ha_t = t; ha_v = HSS; hbase = t - 1; end
      m_lines = vr ? 0 : (ltot > 2047 ? 2047 : ltot);
      if (m_state == 1 && hr) m_first = 0;
      m_bad = vr ? 0 : int'(m_bad || badnow);
      if (m_state == 0) begin
        if (vr) begin m_state = 1; m_gf = 0; m_first = 1; end
      end else if (m_state == 1) begin
        if (tout) m_state = 0;
        else if (vr) begin
          if (fok) begin m_gf++; if (m_gf == 2) m_state = 2; end
          else m_gf = 0;
        end
      end else if (badnow || tout || (vr && !fok)) begin
        e_se = 1; m_state = 0;
      end
      m_phs = int'(hs); m_pvs = int'(vs);
    end
    valid = 1;
  endtask
  task automatic run_lock();
    for (int i = 0; i < 4 * VT * HT && !locked; i++) step();
    chk("lock_acquired", int'(locked), 1);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  int v0, s0, f0;
  initial begin
    rst_req = 3;
    run(4);
    chk("rst_hpos", int'(hpos_rec), 0);
    chk("rst_vpos", int'(vpos_rec), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_sync_err", int'(sync_err), 0);
    run_lock();
    chk("vrises_to_lock", n_vr, 3);
    f0 = n_fs;
    for (int i = 0; i < 3 * VT * HT && n_vr < 5; i++) step();
    run(2);
    chk("frame_start_count", n_fs - f0, 2);
`ifdef VGA_DEC_STATS_EN
    chk("last_h_period", int'(last_h_period), HT);
    chk("last_v_lines", int'(last_v_lines), VT);
`endif
    // one short line while locked
    v0 = n_vr; s0 = n_serr; hadj = -1;
    run(4 * HT);
    chk("short_line_err", n_serr - s0, 1);
    chk("short_line_unlock", int'(locked), 0);
`ifdef VGA_DEC_STATS_EN
    chk("err_count", int'(err_count), 1);
`endif
    run_lock();
    chk("relock_vrises", n_vr - v0, 3);
    // one frame one line short while locked
    s0 = n_serr; vadj = -1;
    for (int i = 0; i < 3 * VT * HT && n_serr == s0; i++) step();
    chk("short_frame_err", n_serr - s0, 1);
    chk("short_frame_unlock", int'(locked), 0);
    run_lock();
    // hsync dropout while locked
    s0 = n_serr; hmask = 2 * HT + 4;
    run(4 * HT);
    chk("dropout_locked_err", n_serr - s0, 1);
    chk("dropout_locked_unlock", int'(locked), 0);
    // hsync dropout while measuring
    v0 = n_vr;
    for (int i = 0; i < 2 * VT * HT && n_vr == v0; i++) step();
    s0 = n_serr; hmask = 2 * HT + 4;
    run(4 * HT);
    chk("dropout_measure_no_err", n_serr - s0, 0);
    chk("dropout_measure_unlocked", int'(locked), 0);
    // reset mid-frame while locked
    run_lock();
    run(VT * HT / 2);
    rst_req = 1;
    run(2);
    chk("midrst_hpos", int'(hpos_rec), 0);
    chk("midrst_vpos", int'(vpos_rec), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_display", int'(display_on_rec), 0);
    chk("midrst_sync_err", int'(sync_err), 0);
    run_lock();
    chk("midrst_vrises_to_lock", n_vr, 3);
    rnd = 1;
    run(12000);
    rnd = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
